// File: rtl/bram_lsu_pkg.sv
// Shared definitions for the BRAM load/store unit: funct3 codes, FSM states and
// access legality helpers.
package bram_lsu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, DATA, HOLD} state_t;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 > SW;
    return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
  endfunction

  // Halves need an even offset, words need offset 0 (LH/LHU/SH share funct3[1:0]=1).
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return ((funct3[1:0] == 2'd1) && offset[0]) ||
           ((funct3[1:0] == 2'd2) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/bram_lsu_if.sv
// Request/response handshake bundle between a requester (master) and the LSU (slave).
interface bram_lsu_if #(parameter int ADDR_WIDTH = 10);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/bram_lsu_load_align.sv
// Combinational load lane selection and sign/zero extension of a BRAM read word.
module lsu_load_align
  import bram_lsu_pkg::*;
(
  input  logic [31:0] mem_do,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_do[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? mem_do[31:16] : mem_do[15:0];

  // NOTE: default assignment first so every path drives rdata and no latch is inferred.
  always_comb begin
    rdata = '0;
    case (funct3)
      LB:      rdata = {{24{byte_sel[7]}}, byte_sel};
      LH:      rdata = {{16{half_sel[15]}}, half_sel};
      LW:      rdata = mem_do;
      LBU:     rdata = {24'd0, byte_sel};
      LHU:     rdata = {16'd0, half_sel};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/bram_lsu.sv
// Single-port BRAM load/store unit with one outstanding access and a response hold register.
// Build option: define BRAM_LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module bram_lsu
  import bram_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bram_lsu_if.slave             bus,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_di,
  input  logic [31:0]           mem_do
);

  state_t      state;
  logic        ready_q;
  logic        valid_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] hold_rdata;
  logic        hold_err;

  logic [1:0]  offset;
  logic        accept;
  logic        req_err;
  logic [31:0] load_rdata;
  logic [31:0] data_rdata;

  assign offset = bus.req_addr[1:0];
  // Gating with reset_n keeps the BRAM port quiet while reset is held.
  assign accept = ready_q & bus.req_valid & reset_n;

`ifdef BRAM_LSU_MISALIGN_TRAP_EN
  assign req_err = funct3_illegal(bus.req_we, bus.req_funct3) | misaligned(bus.req_funct3, offset);
`else
  assign req_err = funct3_illegal(bus.req_we, bus.req_funct3);
`endif

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 4'd0;
    mem_addr = '0;
    mem_di   = '0;
    if (accept && !req_err) begin
      mem_en   = 1'b1;
      mem_addr = bus.req_addr[ADDR_WIDTH+1:2];
      if (bus.req_we) begin
        case (bus.req_funct3)
          SB: begin
            mem_we = 4'b0001 << offset;
            mem_di = {4{bus.req_wdata[7:0]}};
          end
          SH: begin
            mem_we = 4'b0011 << {offset[1], 1'b0};
            mem_di = {2{bus.req_wdata[15:0]}};
          end
          default: begin
            mem_we = 4'hF;
            mem_di = bus.req_wdata;
          end
        endcase
      end
    end
  end

  lsu_load_align u_load_align (
    .mem_do (mem_do),
    .funct3 (funct3_q),
    .offset (offset_q),
    .rdata  (load_rdata)
  );

  assign data_rdata = (err_q || we_q) ? 32'd0 : load_rdata;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = (state == DATA) ? data_rdata : (state == HOLD) ? hold_rdata : 32'd0;
  assign bus.rsp_err   = (state == DATA) ? err_q      : (state == HOLD) ? hold_err   : 1'b0;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      funct3_q   <= 3'd0;
      offset_q   <= 2'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: the hold register is reset too, so no stale response can leak after reset.
      hold_rdata <= 32'd0;
      hold_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q <= bus.req_funct3;
            offset_q <= offset;
            we_q     <= bus.req_we;
            err_q    <= req_err;
            state    <= DATA;
            ready_q  <= 1'b0;
            valid_q  <= 1'b1;
          end
        end
        DATA: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end else begin
            hold_rdata <= data_rdata;
            hold_err   <= err_q;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bram_lsu.md
BRAM_LSU -- requirements
Module: bram_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address width of the attached BRAM port.
REQ-002 SHALL have a 32-bit data path fixed: 4 byte lanes of 8 bits; no data-width parameter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock for all state
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V access size/sign code
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  illegal funct3 or trapped misalignment
- mem_en  out  1  BRAM port enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_WIDTH  BRAM word address, req_addr[ADDR_WIDTH+1:2]
- mem_di  out  32  BRAM write data
- mem_do  in  32  BRAM read data, valid one cycle after mem_en

Function
REQ-004 SHALL implement FSM states IDLE, DATA, HOLD.
REQ-005 IDLE: req_ready=1, rsp_valid=0. On accept, go to DATA; otherwise stay in IDLE.
REQ-006 mem_en/mem_we/mem_addr/mem_di SHALL be driven combinationally from req_* only in the IDLE accept cycle. mem_en=0 and mem_we=0 at all other times and for error requests.
REQ-007 DATA, one cycle after accept: rsp_valid=1, rsp_rdata formatted from mem_do, req_ready=0.
- If rsp_ready=1, go to IDLE.
- Otherwise, capture rsp_rdata/rsp_err into a hold register and go to HOLD.
REQ-008 HOLD: rsp_valid=1, outputs from the hold register, stable until rsp_ready=1, then go to IDLE.
REQ-009 Throughput SHALL be at most one request per 2 cycles. Latency from accept to rsp_valid SHALL be exactly 1 cycle.
REQ-010 Every accepted request, load or store, SHALL produce exactly one response.
REQ-011 Stores SHALL map as follows (o = req_addr[1:0]):
- SB (0): mem_we = 1<<o, mem_di = {4{wdata[7:0]}}
- SH (1): mem_we = 4'b0011<<{o[1],1'b0}, mem_di = {2{wdata[15:0]}}
- SW (2): mem_we = 4'hF, mem_di = wdata
REQ-012 Loads SHALL map as follows: LB (0) sign-extended byte lane o; LH (1) sign-extended half; LW (2); LBU (4) zero-extended; LHU (5) zero-extended.
REQ-013 funct3 SHALL be illegal for store values 3-7 and load values 3, 6, 7. An illegal funct3 SHALL give rsp_err=1, rsp_rdata=0, and no memory access.
REQ-014 Simultaneous req_valid and a pending response SHALL leave the request unaccepted; the requester holds req_*.

Reset
REQ-015 While reset_n=0, the block SHALL be in IDLE with rsp_valid=0, rsp_rdata=0, rsp_err=0, hold register=0, mem_en=0 and mem_we=0.
REQ-016 Reset asserted in DATA or HOLD SHALL drop the pending response, with no response after release.
REQ-017 The first accept SHALL be possible in the first clk edge after reset_n rises.

Configuration
REQ-018 Macro BRAM_LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
- Defined: a half access with o[0]=1 or a word access with o≠0 SHALL give rsp_err=1, rsp_rdata=0, and no memory access.
- Undefined: low address bits SHALL be ignored (half uses o[1] only, word uses lane 0), and rsp_err SHALL be set only by an illegal funct3.

Structure
REQ-019 Shared package bram_lsu_pkg SHALL hold the funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum.
REQ-020 Load extraction and extension SHALL live in combinational sub-module lsu_load_align (inputs mem_do, funct3, offset; output 32-bit rdata).

Verification
REQ-021 Bench SHALL preload word address 5 with 0x8000_00F1 and cover:
- LB addr 0x14 -> rsp_valid on the next cycle, rdata 0xFFFF_FFF1, err 0.
- LHU addr 0x16 -> rdata 0x0000_8000; LH addr 0x16 -> rdata 0xFFFF_8000.
- SB addr 0x15, wdata 0xAB -> mem_we 4'b0010, mem_di 0xABAB_ABAB; then LW 0x14 -> rdata 0x8000_ABF1.
- LW with rsp_ready held low 3 cycles -> state HOLD, rsp_rdata stable, req_ready 0, exactly one handshake.
- LW addr 0x15 -> with the macro: err 1, mem_en 0; without it: rdata equals word 5, err 0.
- funct3=3 load -> err 1, rdata 0. reset_n pulsed low in DATA -> no rsp_valid after release.
